// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared FSM state encoding and default widths for mem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_AW_DEFAULT = 5;
    localparam int c_DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-requester combinational round-robin grant, one-hot output.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention: the pointer names the port that wins this round
            2'b11:   grant = pointer ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Two-port round-robin arbiter for a single-port data memory.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = c_AW_DEFAULT,
    parameter int DW = c_DW_DEFAULT
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Req0,
    input  logic          Req1,
    input  logic          Wr0,
    input  logic          Wr1,
    input  logic [AW-1:0] Adr0,
    input  logic [AW-1:0] Adr1,
    input  logic [DW-1:0] WData0,
    input  logic [DW-1:0] WData1,
    output logic          Ack0,
    output logic          Ack1,
    output logic [DW-1:0] RData0,
    output logic [DW-1:0] RData1,
    output logic          MemWrEn,
    output logic [AW-1:0] MemAdr,
    output logic [DW-1:0] MemDataIn,
    input  logic [DW-1:0] MemDataOut
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ptr;
    logic          r_gnt;
    logic          r_wr;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic [1:0]    w_req;
    logic [1:0]    w_grant;

    assign w_req  = {Req1, Req0};
    assign RData0 = r_rdata0;
    assign RData1 = r_rdata1;

    rr_arb2 u_rr_arb2 (
        .req     (w_req),
        .pointer (r_ptr),
        .grant   (w_grant)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory outputs are only live in ACCESS so the negedge write fires once
    always_comb begin
        w_state_nxt = r_state;
        Ack0        = 1'b0;
        Ack1        = 1'b0;
        MemWrEn     = 1'b0;
        MemAdr      = '0;
        MemDataIn   = '0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_state_nxt = DONE;
                MemWrEn     = r_wr;
                MemAdr      = r_adr;
                MemDataIn   = r_wdata;
            end
            DONE: begin
                w_state_nxt = IDLE;
                Ack0        = ~r_gnt;
                Ack1        = r_gnt;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_ptr    <= 1'b0;
            r_gnt    <= 1'b0;
            r_wr     <= 1'b0;
            r_adr    <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (r_state == IDLE && (|w_req)) begin
                r_gnt   <= w_grant[1];
                r_wr    <= w_grant[1] ? Wr1    : Wr0;
                r_adr   <= w_grant[1] ? Adr1   : Adr0;
                r_wdata <= w_grant[1] ? WData1 : WData0;
            end
            if (r_state == ACCESS && !r_wr) begin
                if (r_gnt) begin
                    r_rdata1 <= MemDataOut;
                end else begin
                    r_rdata0 <= MemDataOut;
                end
            end
            // Hand priority to the other port once this access retires
            if (r_state == DONE) begin
                r_ptr <= ~r_gnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 5, memory word-address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have port Clk input 1, single clock; all state updates on posedge.
REQ-004 SHALL have port Rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have ports Req0/Req1 input 1, per-port access request, held until Ack.
REQ-006 SHALL have ports Wr0/Wr1 input 1, per-port access type: 1 write, 0 read.
REQ-007 SHALL have ports Adr0/Adr1 input AW, per-port word address.
REQ-008 SHALL have ports WData0/WData1 input DW, per-port write data.
REQ-009 SHALL have ports Ack0/Ack1 output 1, one-cycle completion pulse.
REQ-010 SHALL have ports RData0/RData1 output DW, registered read data, valid while Ack is high and held until the next read completion on that port.
REQ-011 SHALL have port MemWrEn output 1, write enable to the data memory.
REQ-012 SHALL have port MemAdr output AW, address to the data memory.
REQ-013 SHALL have port MemDataIn output DW, write data to the data memory.
REQ-014 SHALL have port MemDataOut input DW, combinational read data from the data memory.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, DONE; transitions IDLE->ACCESS when any Req is high, ACCESS->DONE unconditionally, DONE->IDLE unconditionally.
REQ-016 SHALL, in IDLE with any Req high, grant one port and latch that port's Wr, Adr and WData into internal registers at the same edge.
REQ-017 SHALL arbitrate round-robin: on a single request, grant that port; on simultaneous requests, grant the port named by the priority pointer.
REQ-018 SHALL set the priority pointer to the non-granted port at the DONE->IDLE edge.
REQ-019 SHALL, in ACCESS only, drive MemAdr and MemDataIn from the latched values and MemWrEn equal to the latched Wr.
REQ-020 SHALL drive MemWrEn 0 in IDLE and DONE, so that the memory's negedge write occurs exactly once, mid-ACCESS.
REQ-021 SHALL, on a granted read, capture MemDataOut into that port's RData at the ACCESS->DONE edge.
REQ-022 SHALL leave RData unchanged on a write completion.
REQ-023 SHALL assert Ack of the granted port only during DONE, and never assert both Acks at once.
REQ-024 SHALL give latency from Req sampled at edge N to Ack high in cycle N+2, with throughput of one access per 3 cycles.
REQ-025 SHALL ignore a port's Req during its DONE cycle; a Req still high in the following IDLE is treated as a new request.
REQ-026 SHALL complete an access that was latched even if Req drops after the grant edge; Ack is still pulsed.
REQ-027 SHALL, when Req0 and Req1 are held continuously, alternate grants 0,1,0,1,... with no port starving.
REQ-028 SHALL use no address arithmetic: Adr is passed through unchanged, with no wrap or range check.

Reset
REQ-029 SHALL, while Rst_n is 0, force state IDLE, priority pointer to port 0, Ack0/Ack1 0, MemWrEn 0, MemAdr 0, MemDataIn 0, RData0/RData1 0, and all latches 0.
REQ-030 SHALL apply reset asynchronously, including mid-ACCESS: MemWrEn drops immediately, the in-flight access is abandoned with no Ack, and the first edge after release is in IDLE.

Structure
REQ-031 SHALL place the state enumeration (IDLE/ACCESS/DONE) and default AW/DW constants in shared package mem_arb_pkg.
REQ-032 SHALL implement grant selection as combinational sub-module rr_arb2, with inputs req[1:0] and pointer and a one-hot grant[1:0] output; all registers stay in mem_arbiter.

Verification
REQ-033 SHALL cover a single write: Req0=1, Wr0=1, Adr0=5, WData0=0xDEADBEEF -> MemWrEn=1 with MemAdr=5 for exactly one cycle, Ack0 at N+2, Ack1 never asserted.
REQ-034 SHALL cover read-back: after REQ-033, Req1=1, Wr1=0, Adr1=5 -> RData1=0xDEADBEEF with Ack1 at N+2, RData0 unchanged.
REQ-035 SHALL cover contention: Req0=Req1=1 held for 12 cycles after reset -> grants in order 0,1,0,1, with 4 Acks total and one Ack every 3 cycles.
REQ-036 SHALL cover mid-access reset: Rst_n pulled to 0 during ACCESS of a write to Adr=7 -> MemWrEn falls asynchronously, no Ack, all outputs 0, and the pointer returns to 0.
REQ-037 SHALL cover Req withdrawal: Req1 dropped one cycle after grant -> Ack1 still pulses at N+2 and the FSM returns to IDLE.
